// File: rtl/maxpool_2x2_s2_int4_if.sv
// Stream bundle between the window source and the 2x2 stride-2 max pooler.
// Both directions are valid-only streams with no ready: a beat transfers on every
// rising clock edge where its valid is high, and the receiver must always accept it.
interface maxpool_2x2_s2_int4_if;
  logic [2:0]  sel_in;
  logic        frame_start;
  logic        win_valid;
  logic [15:0] win_in;
  logic [3:0]  pool_out;
  logic        pool_valid;
  logic        frame_done;

  modport master (
    output sel_in,
    output frame_start,
    output win_valid,
    output win_in,
    input  pool_out,
    input  pool_valid,
    input  frame_done
  );

  modport slave (
    input  sel_in,
    input  frame_start,
    input  win_valid,
    input  win_in,
    output pool_out,
    output pool_valid,
    output frame_done
  );
endinterface

// File: rtl/maxpool_2x2_s2_int4.sv
// 2x2 stride-2 max pooling over a stream of int4 2x2 windows, 2-cycle latency.
// Define POOL_SIGNED_EN to compare nibbles as two's-complement; otherwise unsigned.
module maxpool_2x2_s2_int4 (
  input  logic                        clk,
  input  logic                        rst_n,
  maxpool_2x2_s2_int4_if.slave        bus
);

  localparam int unsigned W1 = 8;
  localparam int unsigned W2 = 14;
  localparam int unsigned W3 = 28;
  localparam int unsigned W4 = 56;
  localparam int unsigned W5 = 112;
  localparam int unsigned W6 = 224;

  logic [2:0] sel_q, sel_d;
  logic [7:0] col_q, col_d;
  logic [7:0] row_q, row_d;
  logic [7:0] width_m1;
  logic       qualify;
  logic       last;

  logic [3:0] m0_q, m0_d;
  logic [3:0] m1_q, m1_d;
  logic       v1_q, v1_d;
  logic       l1_q, l1_d;

  logic [3:0] pool_out_q, pool_out_d;
  logic       pool_valid_q, pool_valid_d;
  logic       frame_done_q, frame_done_d;

  // The winner is returned as its original bit pattern in both modes.
  function automatic logic [3:0] nib_max(input logic [3:0] a, input logic [3:0] b);
`ifdef POOL_SIGNED_EN
    nib_max = ($signed(a) >= $signed(b)) ? a : b;
`else
    nib_max = (a >= b) ? a : b;
`endif
  endfunction

  always_comb begin
    case (sel_q)
      3'd1:    width_m1 = 8'(W2 - 1);
      3'd2:    width_m1 = 8'(W3 - 1);
      3'd3:    width_m1 = 8'(W4 - 1);
      3'd4:    width_m1 = 8'(W5 - 1);
      3'd5:    width_m1 = 8'(W6 - 1);
      default: width_m1 = 8'(W1 - 1);
    endcase
  end

  // A frame_start beat is pixel (0,0) regardless of counter state, so the
  // following beat is (0,1); it never qualifies and never ends a frame.
  always_comb begin
    sel_d   = sel_q;
    col_d   = col_q;
    row_d   = row_q;
    qualify = 1'b0;
    last    = 1'b0;
    if (bus.win_valid) begin
      if (bus.frame_start) begin
        sel_d = bus.sel_in;
        col_d = 8'd1;
        row_d = 8'd0;
      end else begin
        qualify = row_q[0] & col_q[0];
        if (col_q == width_m1) begin
          col_d = 8'd0;
          if (row_q == width_m1) begin
            row_d = 8'd0;
            last  = 1'b1;
          end else begin
            row_d = row_q + 8'd1;
          end
        end else begin
          col_d = col_q + 8'd1;
        end
      end
    end
  end

  always_comb begin
    m0_d         = nib_max(bus.win_in[3:0], bus.win_in[7:4]);
    m1_d         = nib_max(bus.win_in[11:8], bus.win_in[15:12]);
    v1_d         = qualify;
    l1_d         = last & qualify;
    pool_out_d   = v1_q ? nib_max(m0_q, m1_q) : pool_out_q;
    pool_valid_d = v1_q;
    frame_done_d = l1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q        <= 3'd0;
      col_q        <= 8'd0;
      row_q        <= 8'd0;
      m0_q         <= 4'd0;
      m1_q         <= 4'd0;
      v1_q         <= 1'b0;
      l1_q         <= 1'b0;
      pool_out_q   <= 4'd0;
      pool_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      col_q        <= col_d;
      row_q        <= row_d;
      m0_q         <= m0_d;
      m1_q         <= m1_d;
      v1_q         <= v1_d;
      l1_q         <= l1_d;
      pool_out_q   <= pool_out_d;
      pool_valid_q <= pool_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.pool_out   = pool_out_q;
  assign bus.pool_valid = pool_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule
